ila_fifo_readout: RTL and testbench
===================================

Name: ila_fifo_readout

Overview:
- Read-side consumer of the ILA sample FIFO.
- On a host request, pops a programmed number of sample words from the cascaded FIFO and compensates for the FIFO's registered read latency.
- Serialises each word LSB-byte-first onto a byte stream with a valid/ready handshake, which feeds the host transport (UART/SPI TX).
- Sits between the FIFO pop port and the host link.

Parameters:
- WIDTH, 20, sample word width; must match the FIFO data width.
- READ_LATENCY, 2, rclk cycles from the fifo_pop_o pulse to valid fifo_do_i (BRAM output register plus fabric output register). Legal range 1..7.
- CNT_W, 16, width of the word-count input.

Ports:
- rclk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle request to begin readout; ignored while busy_o=1.
- num_words_i  in  CNT_W  number of words to read; sampled on an accepted start_i.
- abort_i  in  1  synchronous abort; returns to IDLE on the next edge.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a readout completes (not asserted on abort).
- fifo_empty_i  in  1  FIFO EMPTY flag.
- fifo_pop_o  out  1  one-cycle pop strobe to the FIFO.
- fifo_do_i  in  WIDTH  FIFO read data.
- byte_o  out  8  stream data.
- byte_valid_o  out  1  stream valid.
- byte_ready_i  in  1  stream ready from the transport.

Behaviour:
- Reset values (rst=0): all outputs 0; state IDLE; remaining-word counter, latency counter, byte index and shift register all 0.
- NB = ceil(WIDTH/8) bytes per word. Byte k = word[8k+7:8k]; bits above WIDTH in the last byte are zero-padded.
- IDLE:
  - start_i=1 latches num_words_i into rem.
  - If num_words_i=0: go to DONE.
  - Otherwise: go to POP.
- POP:
  - If fifo_empty_i=1: stay in POP and keep fifo_pop_o=0 (underrun stall, no timeout).
  - Otherwise: drive fifo_pop_o=1 for exactly this cycle, clear the latency counter, go to WAIT.
  - fifo_pop_o is never high in two consecutive cycles and never high while fifo_empty_i=1.
- WAIT:
  - Counts READ_LATENCY cycles after the pop cycle.
  - On the cycle where the count reaches READ_LATENCY, captures fifo_do_i into the shift register, sets byte index to 0, goes to SEND.
- SEND:
  - byte_valid_o=1; byte_o = byte[index].
  - byte_o must stay stable until the handshake completes (byte_valid_o & byte_ready_i on the same edge).
  - On handshake with index<NB-1: increment index.
  - On handshake with index=NB-1: decrement rem. If rem becomes 0, go to DONE (or CSUM, see Optional Feature); otherwise go to POP.
  - byte_ready_i held low stalls indefinitely with no data change.
- DONE: done_o=1 for one cycle, then return to IDLE.
  - Minimum latency for num_words=1, with FIFO non-empty and ready tied high: start cycle → POP (1) → WAIT (READ_LATENCY) → NB byte cycles → DONE.
- abort_i: from any state, go to IDLE next edge.
  - byte_valid_o and fifo_pop_o go to 0 the same edge; no done_o.
  - A word already popped is discarded.
  - abort_i has priority over start_i and over the handshake.
- Reset mid-operation: immediate return to reset values; partial bytes are not completed.
- rem is CNT_W bits and never wraps: decrement only occurs while rem≥1.

Optional Feature:
- Macro ILA_READOUT_CHECKSUM_EN.
- Defined:
  - Adds state CSUM after the last data byte of the burst.
  - Emits one extra byte = XOR of every data byte handshaken in this burst, using the same valid/ready rules, then goes to DONE.
  - The checksum accumulator clears on an accepted start_i.
  - For num_words=0 the checksum byte 0x00 is still sent.
- Not defined: no CSUM state and no accumulator logic; the last data byte goes directly to DONE.

Test Plan:
- WIDTH=20, READ_LATENCY=2, num_words=1, FIFO word 0xABCDE, ready=1 → fifo_pop_o pulses once; data captured 2 cycles later; bytes 0xDE, 0xBC, 0x0A; done_o pulses the cycle after 0x0A.
- num_words=3, words 0x00001/0x00002/0x00003, ready toggling 1-0 every cycle → exactly 3 pops; 9 bytes 01,00,00,02,00,00,03,00,00; byte_o stable during each stall.
- num_words=2, fifo_empty_i held 1 for 10 cycles before the second pop → stays in POP, fifo_pop_o=0 throughout, then resumes; 6 bytes, one done_o.
- num_words=0 → no pop, no bytes (checksum build: a single 0x00 byte), done_o within 2 cycles.
- abort_i mid-SEND after the 1st byte of a 4-word burst → byte_valid_o=0 the next cycle, busy_o=0, no done_o; a new start with num_words=1 then completes normally.
- ILA_READOUT_CHECKSUM_EN defined, words 0x12345, 0x0F0F0 → bytes 45,23,01,F0,F0,00, then checksum 0x67.

Source files
------------

// File: rtl/ila_fifo_readout.sv
// ila_fifo_readout
//   Read-side consumer of the ILA sample FIFO. On a host request it pops a
//   programmed number of words from the FIFO and waits out the FIFO's
//   registered read latency before capturing each word. It then sends the
//   word LSB-byte-first on a valid/ready byte stream toward the host
//   transport.
//
//   Optional feature: define ILA_READOUT_CHECKSUM_EN to append one checksum
//   byte after the burst. The checksum is the XOR of every data byte
//   accepted in that burst.
//
// Ports
//   rclk          clock, rising edge
//   rst           asynchronous active-low reset
//   start_i       request to begin readout (ignored while busy_o=1)
//   num_words_i   word count, sampled on an accepted start_i
//   abort_i       synchronous abort, back to idle on the next edge
//   busy_o        high in every state except idle
//   done_o        one-cycle pulse on normal completion
//   fifo_empty_i  FIFO empty flag
//   fifo_pop_o    one-cycle pop strobe to the FIFO
//   fifo_do_i     FIFO read data (READ_LATENCY cycles after the pop)
//   byte_o        stream data
//   byte_valid_o  stream valid
//   byte_ready_i  stream ready
module ila_fifo_readout #(
  parameter int WIDTH        = 20,
  parameter int READ_LATENCY = 2,
  parameter int CNT_W        = 16
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  input  logic [WIDTH-1:0] fifo_do_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i
);

  localparam int NB    = (WIDTH + 7) / 8;
  localparam int SW    = NB * 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int LAT_W = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LATENCY - 1);

`ifdef ILA_READOUT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4,
    S_CSUM = 3'd5
  } state_e;
  // The end of a burst passes through the checksum byte first.
  localparam state_e S_END = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;
  localparam state_e S_END = S_DONE;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [LAT_W-1:0] lat_q,   lat_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  // The shift register moves right by one byte per handshake, so the
  // current byte is always in bits [7:0] and byte_o comes straight from flops.
  logic [SW-1:0]    shift_q, shift_d;
`ifdef ILA_READOUT_CHECKSUM_EN
  logic [7:0]       csum_q,  csum_d;
`endif

  // Next-state and datapath update; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef ILA_READOUT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
      rem_d   = {CNT_W{1'b0}};
      lat_d   = {LAT_W{1'b0}};
      idx_d   = {IDX_W{1'b0}};
      shift_d = {SW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_d = num_words_i;
`ifdef ILA_READOUT_CHECKSUM_EN
            csum_d = 8'h00;
`endif
            if (num_words_i == {CNT_W{1'b0}}) begin
              state_d = S_END;
            end else begin
              state_d = S_POP;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_POP: begin
          // An empty FIFO stalls here with no timeout.
          if (!fifo_empty_i) begin
            lat_d   = {LAT_W{1'b0}};
            state_d = S_WAIT;
          end else begin
            state_d = S_POP;
          end
        end
        S_WAIT: begin
          // Read data is valid on the READ_LATENCY-th cycle after the pop.
          if (lat_q == LAST_LAT) begin
            shift_d = SW'(fifo_do_i);
            idx_d   = {IDX_W{1'b0}};
            state_d = S_SEND;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        S_SEND: begin
          if (byte_ready_i) begin
`ifdef ILA_READOUT_CHECKSUM_EN
            csum_d = csum_q ^ shift_q[7:0];
`endif
            shift_d = shift_q >> 4'd8;
            if (idx_q == LAST_IDX) begin
              idx_d = {IDX_W{1'b0}};
              // SEND is only reachable with rem >= 1, so this cannot wrap.
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = S_END;
              end else begin
                state_d = S_POP;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = S_SEND;
          end
        end
`ifdef ILA_READOUT_CHECKSUM_EN
        S_CSUM: begin
          if (byte_ready_i) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CSUM;
          end
        end
`endif
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= {CNT_W{1'b0}};
      lat_q   <= {LAT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      shift_q <= {SW{1'b0}};
`ifdef ILA_READOUT_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef ILA_READOUT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

  // The pop is gated by the live empty flag, so the strobe never fires into
  // an empty FIFO. An abort in the same cycle suppresses the pop, so no word
  // is lost.
  assign fifo_pop_o = (state_q == S_POP) & ~fifo_empty_i & ~abort_i;

`ifdef ILA_READOUT_CHECKSUM_EN
  assign byte_valid_o = (state_q == S_SEND) | (state_q == S_CSUM);
  assign byte_o       = (state_q == S_CSUM) ? csum_q : shift_q[7:0];
`else
  assign byte_valid_o = (state_q == S_SEND);
  assign byte_o       = shift_q[7:0];
`endif

endmodule

// File: tb/tb_ila_fifo_readout.sv
module tb_ila_fifo_readout;

  localparam int WIDTH = 20;
  localparam int LAT   = 2;
  localparam int CNT_W = 16;
  localparam int NB    = (WIDTH + 7) / 8;
`ifdef ILA_READOUT_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic             rclk = 1'b0;
  logic             rst  = 1'b0;
  logic             start_i = 1'b0;
  logic [CNT_W-1:0] num_words_i = '0;
  logic             abort_i = 1'b0;
  logic             busy_o, done_o, fifo_pop_o, byte_valid_o;
  logic             fifo_empty_i = 1'b1;
  logic [WIDTH-1:0] fifo_do_i = '0;
  logic [7:0]       byte_o;
  logic             byte_ready_i = 1'b1;

  ila_fifo_readout #(.WIDTH(WIDTH), .READ_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .rclk(rclk), .rst(rst), .start_i(start_i), .num_words_i(num_words_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o), .fifo_do_i(fifo_do_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // FIFO environment: word queue plus a read-latency delay line.
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] dl[0:7];
  bit               force_empty = 1'b0;
  bit               rand_empty = 1'b0;
  int               ready_mode = 0;   // 0 always high, 1 toggle, 2 random
  bit               dut_pop = 1'b0;

  // Observation log.
  logic [7:0] rx_q[$];
  int pops = 0, dones = 0, start_cyc = 0, done_cyc = 0;

  // Behavioural model: phase 0 idle, 1 pop, 2 latency wait, 3 data bytes, 4 checksum, 5 done.
  int               m_phase = 0;
  int               m_words = 0;
  int               m_wait = 0;
  logic [7:0]       m_bq[$];
  logic [7:0]       m_csum = 8'h00;
  logic [WIDTH-1:0] m_fifo[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    m_fifo.push_back(w);
  endtask

  task automatic model_advance();
    logic [WIDTH-1:0] w;
    if (!rst) begin
      m_phase = 0; m_words = 0; m_bq.delete();
    end else if (abort_i) begin
      m_phase = 0; m_bq.delete();
    end else begin
      case (m_phase)
        0: if (start_i) begin
             m_words = int'(num_words_i);
             m_csum  = 8'h00;
             m_phase = (m_words == 0) ? (CS_EN ? 4 : 5) : 1;
           end
        1: if (!fifo_empty_i) begin
             w = (m_fifo.size() > 0) ? m_fifo.pop_front() : '0;
             m_bq.delete();
             for (int k = 0; k < NB; k++) m_bq.push_back(8'((w >> (8 * k)) & 20'hFF));
             m_wait  = LAT;
             m_phase = 2;
           end
        2: begin
             m_wait--;
             if (m_wait == 0) m_phase = 3;
           end
        3: if (byte_ready_i) begin
             m_csum = m_csum ^ m_bq[0];
             void'(m_bq.pop_front());
             if (m_bq.size() == 0) begin
               m_words--;
               m_phase = (m_words == 0) ? (CS_EN ? 4 : 5) : 1;
             end
           end
        4: if (byte_ready_i) m_phase = 5;
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock cycle: compare at the falling edge, update environment after the rising edge.
  task automatic step();
    bit e_busy, e_done, e_pop, e_valid;
    logic [7:0] e_byte;
    fifo_empty_i = force_empty || (fifo_q.size() == 0);
    @(negedge rclk);
    e_busy  = rst && (m_phase != 0);
    e_done  = rst && (m_phase == 5);
    e_pop   = rst && (m_phase == 1) && !fifo_empty_i && !abort_i;
    e_valid = rst && (m_phase == 3 || m_phase == 4);
    e_byte  = (m_phase == 3) ? m_bq[0] : m_csum;
    chk("busy_o", 32'(busy_o), 32'(e_busy));
    chk("done_o", 32'(done_o), 32'(e_done));
    chk("fifo_pop_o", 32'(fifo_pop_o), 32'(e_pop));
    chk("byte_valid_o", 32'(byte_valid_o), 32'(e_valid));
    if (e_valid) chk("byte_o", 32'(byte_o), 32'(e_byte));
    if (fifo_pop_o) pops++;
    if (done_o) begin dones++; done_cyc = cyc; end
    if (byte_valid_o && byte_ready_i && !abort_i) rx_q.push_back(byte_o);
    dut_pop = fifo_pop_o;
    model_advance();
    @(posedge rclk);
    #1;
    for (int i = 7; i > 0; i--) dl[i] = dl[i - 1];
    dl[0] = WIDTH'($urandom);
    if (dut_pop && fifo_q.size() > 0) dl[0] = fifo_q.pop_front();
    fifo_do_i = dl[LAT - 1];
    start_i = 1'b0;
    abort_i = 1'b0;
    if (rand_empty) force_empty = ($urandom_range(0, 7) == 0);
    case (ready_mode)
      0: byte_ready_i = 1'b1;
      1: byte_ready_i = ~byte_ready_i;
      default: byte_ready_i = ($urandom_range(0, 3) != 0);
    endcase
    cyc++;
  endtask

  task automatic start_burst(input int n);
    start_i = 1'b1;
    num_words_i = CNT_W'(n);
    start_cyc = cyc;
    step();
  endtask

  task automatic run_idle(input string name);
    int budget = 3000;
    while (m_phase != 0 && budget > 0) begin step(); budget--; end
    if (budget == 0) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    rx_q.delete(); pops = 0; dones = 0; done_cyc = -1;
  endtask

  task automatic chk_bytes(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp_b[$];
    int budget;
    for (int i = 0; i < 8; i++) dl[i] = '0;

    // Reset state
    repeat (3) step();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(byte_valid_o), 32'd0);
    chk("rst_byte", 32'(byte_o), 32'd0);
    rst = 1'b1;
    step();

    // Single word, ready always high
    clear_log();
    ready_mode = 0; byte_ready_i = 1'b1;
    load(20'hABCDE);
    start_burst(1);
    run_idle("t1");
    exp_b = '{8'hDE, 8'hBC, 8'h0A};
    if (CS_EN) exp_b.push_back(8'h68);
    chk_bytes("t1", exp_b);
    chk("t1_pops", 32'(pops), 32'd1);
    chk("t1_dones", 32'(dones), 32'd1);
    chk("t1_latency", 32'(done_cyc - start_cyc), CS_EN ? 32'd8 : 32'd7);

    // Three words, ready toggling
    clear_log();
    ready_mode = 1;
    load(20'h00001); load(20'h00002); load(20'h00003);
    start_burst(3);
    run_idle("t2");
    exp_b = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
    if (CS_EN) exp_b.push_back(8'h00);
    chk_bytes("t2", exp_b);
    chk("t2_pops", 32'(pops), 32'd3);
    chk("t2_dones", 32'(dones), 32'd1);

    // Two words with an empty-FIFO stall before the second pop
    clear_log();
    ready_mode = 0; byte_ready_i = 1'b1;
    load(20'h12345); load(20'h0F0F0);
    start_burst(2);
    budget = 50;
    while (pops < 1 && budget > 0) begin step(); budget--; end
    chk("t3_first_pop", 32'(pops), 32'd1);
    force_empty = 1'b1;
    repeat (10) step();
    chk("t3_stall_pops", 32'(pops), 32'd1);
    chk("t3_stall_busy", 32'(busy_o), 32'd1);
    force_empty = 1'b0;
    run_idle("t3");
    exp_b = '{8'h45, 8'h23, 8'h01, 8'hF0, 8'hF0, 8'h00};
    if (CS_EN) exp_b.push_back(8'h67);
    chk_bytes("t3", exp_b);
    chk("t3_pops", 32'(pops), 32'd2);
    chk("t3_dones", 32'(dones), 32'd1);

    // Zero words
    clear_log();
    load(20'h55555);
    start_burst(0);
    run_idle("t4");
    exp_b = '{};
    if (CS_EN) exp_b.push_back(8'h00);
    chk_bytes("t4", exp_b);
    chk("t4_pops", 32'(pops), 32'd0);
    chk("t4_dones", 32'(dones), 32'd1);
    chk("t4_latency", 32'(done_cyc - start_cyc), CS_EN ? 32'd2 : 32'd1);
    fifo_q.delete(); m_fifo.delete();

    // Abort after the first byte of a four-word burst, then a clean burst
    clear_log();
    load(20'h11111); load(20'h22222); load(20'h33333); load(20'h44444);
    start_burst(4);
    budget = 50;
    while (rx_q.size() < 1 && budget > 0) begin step(); budget--; end
    abort_i = 1'b1;
    step();
    chk("t5_valid_after_abort", 32'(byte_valid_o), 32'd0);
    chk("t5_busy_after_abort", 32'(busy_o), 32'd0);
    step();
    chk_bytes("t5a", '{8'h11});
    chk("t5_dones", 32'(dones), 32'd0);
    clear_log();
    start_burst(1);
    run_idle("t5b");
    exp_b = '{8'h22, 8'h22, 8'h02};
    if (CS_EN) exp_b.push_back(8'h02);
    chk_bytes("t5b", exp_b);
    chk("t5b_dones", 32'(dones), 32'd1);
    fifo_q.delete(); m_fifo.delete();

    // Randomized bursts with empty gaps, back-pressure, spurious starts, aborts and resets
    ready_mode = 2;
    rand_empty = 1'b1;
    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) load(WIDTH'($urandom));
      start_burst(n);
      budget = 3000;
      while (m_phase != 0 && budget > 0) begin
        if ($urandom_range(0, 15) == 0) begin
          start_i = 1'b1; num_words_i = CNT_W'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 149) == 0) abort_i = 1'b1;
        if ($urandom_range(0, 299) == 0) rst = 1'b0;
        step();
        rst = 1'b1;
        budget--;
      end
      if (budget == 0) chk("rand_timeout", 32'd1, 32'd0);
      step();
    end
    rand_empty = 1'b0; force_empty = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
